// File: rtl/fifo_wr_port_arbiter.sv
// fifo_wr_port_arbiter: round-robin, burst-limited sharing of one FIFO write port between NUM_REQ producers
module fifo_wr_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 2,
  parameter int IDX_WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     busy_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IDX_WIDTH-1:0] owner, rr_ptr, nxt_ptr, start, idx, hit_idx;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic hit, wr, rel;
  assign nxt_ptr = IDX_WIDTH'((32'(owner) + 32'd1) % NUM_REQ);
  // a releasing owner searches from its successor in the same cycle, so handover has no bubble
  assign start = (state == GRANT) ? nxt_ptr : rr_ptr;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDX_WIDTH'((32'(start) + 32'(i)) % NUM_REQ);
      if (req_i[idx]) begin
        hit = 1'b1;
        hit_idx = idx;
      end
    end
  end
  assign wr = state == GRANT && req_i[owner] && !fifo_full_i;
  assign rel = state == GRANT && (!req_i[owner] || (wr && burst_cnt == CNT_WIDTH'(BURST_LEN - 1)));
  assign fifo_wr_en_o = wr;
  assign ack_o = wr ? NUM_REQ'(1) << owner : '0;
  assign fifo_wdata_o = state == GRANT ? wdata_i[32'(owner)*WIDTH +: WIDTH] : '0;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      burst_cnt <= '0;
      gnt_o <= '0;
      busy_o <= 1'b0;
    end else if (state == IDLE || rel) begin
      if (rel) rr_ptr <= nxt_ptr;
      if (hit) begin
        state <= GRANT;
        owner <= hit_idx;
        burst_cnt <= '0;
        gnt_o <= NUM_REQ'(1) << hit_idx;
        busy_o <= 1'b1;
      end else begin
        state <= IDLE;
        gnt_o <= '0;
        busy_o <= 1'b0;
      end
    end else if (wr) burst_cnt <= burst_cnt + CNT_WIDTH'(1);
endmodule
